counter_sequencer: RTL and testbench

//   Control front-end for an N-bit binary up-counter. Adds start/stop/hold control,
//   a programmable prescaler and a programmable terminal value (period).

---
 rtl/counter_sequencer_pkg.sv | 12 +
 rtl/counter_sequencer_binary_counter_en.sv | 24 ++
 rtl/counter_sequencer.sv | 99 +++++++++
 tb/tb_counter_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer timer controller.
package counter_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_sequencer_binary_counter_en.sv
// N-bit binary up-counter with synchronous clear (priority) and count enable.
module binary_counter_en #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + N'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Timer controller: start/stop/hold FSM, prescaler, latched config and
// terminal compare driving an enabled binary counter.
module counter_sequencer #(
    parameter int N = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic         mode,
    input  logic [N-1:0] period,
    input  logic [P-1:0] prescale,
    output logic         busy,
    output logic         tick,
    output logic         done,
    output logic [N-1:0] count
);

    import counter_sequencer_pkg::*;

    state_t       r_state;
    logic         r_mode_q;
    logic [N-1:0] r_period_q;
    logic [P-1:0] r_prescale_q;
    logic [P-1:0] r_pre_cnt;
    logic         r_busy;
    logic         r_tick;
    logic         r_done;

    logic         w_run;
    logic         w_en;
    logic         w_wrap;
    logic         w_clr;
    logic [N-1:0] w_count;

    assign w_run  = (r_state == RUN);
    assign w_en   = w_run & (r_pre_cnt == r_prescale_q) & ~hold;
    assign w_wrap = w_en & (w_count == r_period_q);
    // Any start (including a restart) or stop zeroes the count; IDLE holds it at zero.
    assign w_clr  = stop | start | ~w_run | w_wrap;

    binary_counter_en #(.N(N)) u_counter (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .q     (w_count)
    );

    // NOTE: the shadow config registers are part of the async reset domain so a
    // mid-run reset leaves no stale period or prescale behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_mode_q     <= MODE_ONESHOT;
            r_period_q   <= '0;
            r_prescale_q <= '0;
            r_pre_cnt    <= '0;
            r_busy       <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            if (stop) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_pre_cnt <= '0;
            end else if (start) begin
                r_state      <= RUN;
                r_busy       <= 1'b1;
                r_pre_cnt    <= '0;
                r_mode_q     <= mode;
                r_period_q   <= period;
                r_prescale_q <= prescale;
            end else if (w_run) begin
                if (!hold) begin
                    r_pre_cnt <= (r_pre_cnt == r_prescale_q) ? '0 : r_pre_cnt + P'(1);
                end
                if (w_wrap) begin
                    r_tick <= 1'b1;
                    if (r_mode_q == MODE_ONESHOT) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy  = r_busy;
    assign tick  = r_tick;
    assign done  = r_done;
    assign count = w_count;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer.
module tb_counter_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       hold;
    logic       mode;
    logic [7:0] period;
    logic [3:0] prescale;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] count;

    int checks;
    int errors;

    counter_sequencer #(.N(8), .P(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .busy     (busy),
        .tick     (tick),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [7:0] per, input logic [3:0] pre);
        mode     = m;
        period   = per;
        prescale = pre;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 1'b0; period = 8'd0; prescale = 4'd0;
        #12;
        exp = 11'd0;
        checks++;
        if ({busy, tick, done, count} !== exp) begin
            $display("FAIL reset_hold: got %h expected %h", {busy, tick, done, count}, exp);
            errors++;
        end
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({busy, tick, done, count} !== exp) begin
            $display("FAIL reset_idle: got %h expected %h", {busy, tick, done, count}, exp);
            errors++;
        end
        // Async reset mid-cycle while running, just as a tick is being flagged.
        do_start(1'b1, 8'd1, 4'd0);
        cyc();
        cyc();
        checks++;
        if ({busy, tick, done, count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            $display("FAIL reset_pre_tick: got %h expected %h", {busy, tick, done, count}, {1'b1, 1'b1, 1'b0, 8'd0});
            errors++;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, tick, done, count} !== exp) begin
            $display("FAIL reset_async: got %h expected %h", {busy, tick, done, count}, exp);
            errors++;
        end
        #1;
        reset = 1'b1;
        cyc();
        checks++;
        if ({busy, tick, done, count} !== exp) begin
            $display("FAIL reset_after: got %h expected %h", {busy, tick, done, count}, exp);
            errors++;
        end
    endtask

    task automatic test_periodic();
        logic [10:0] exp;
        do_start(1'b1, 8'd3, 4'd0);
        period = 8'd9;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) cyc();
            exp = {1'b1, (i % 4 == 0) && (i > 0), 1'b0, 8'(i % 4)};
            checks++;
            if ({busy, tick, done, count} !== exp) begin
                $display("FAIL periodic[%0d]: got %h expected %h", i, {busy, tick, done, count}, exp);
                errors++;
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if ({busy, tick, done, count} !== 11'd0) begin
            $display("FAIL periodic_stop: got %h expected %h", {busy, tick, done, count}, 11'd0);
            errors++;
        end
    endtask

    task automatic test_oneshot();
        logic [10:0] exp;
        do_start(1'b0, 8'd2, 4'd1);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) cyc();
            exp = {i < 6, i == 6, i == 6, (i < 6) ? 8'(i / 2) : 8'd0};
            checks++;
            if ({busy, tick, done, count} !== exp) begin
                $display("FAIL oneshot[%0d]: got %h expected %h", i, {busy, tick, done, count}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_hold();
        logic [10:0] exp;
        do_start(1'b1, 8'd5, 4'd0);
        cyc();
        cyc();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp = {1'b1, 1'b0, 1'b0, 8'd2};
            checks++;
            if ({busy, tick, done, count} !== exp) begin
                $display("FAIL hold_freeze[%0d]: got %h expected %h", i, {busy, tick, done, count}, exp);
                errors++;
            end
        end
        hold = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            exp = {1'b1, j == 4, 1'b0, (j == 4) ? 8'd0 : 8'(2 + j)};
            checks++;
            if ({busy, tick, done, count} !== exp) begin
                $display("FAIL hold_resume[%0d]: got %h expected %h", j, {busy, tick, done, count}, exp);
                errors++;
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_stop();
        do_start(1'b1, 8'd4, 4'd0);
        repeat (4) cyc();
        checks++;
        if (count !== 8'd4) begin
            $display("FAIL stop_pre_count: got %0d expected %0d", count, 4);
            errors++;
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if ({busy, tick, done, count} !== 11'd0) begin
            $display("FAIL stop_terminal: got %h expected %h", {busy, tick, done, count}, 11'd0);
            errors++;
        end
        cyc();
        checks++;
        if ({busy, tick, done, count} !== 11'd0) begin
            $display("FAIL stop_no_late_tick: got %h expected %h", {busy, tick, done, count}, 11'd0);
            errors++;
        end
        mode = 1'b1; period = 8'd3; prescale = 4'd0;
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        cyc();
        checks++;
        if ({busy, tick, done, count} !== 11'd0) begin
            $display("FAIL start_stop_same: got %h expected %h", {busy, tick, done, count}, 11'd0);
            errors++;
        end
    endtask

    task automatic test_restart();
        logic [10:0] exp;
        do_start(1'b1, 8'd7, 4'd0);
        repeat (5) cyc();
        checks++;
        if (count !== 8'd5) begin
            $display("FAIL restart_pre_count: got %0d expected %0d", count, 5);
            errors++;
        end
        do_start(1'b1, 8'd1, 4'd0);
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) cyc();
            exp = {1'b1, (i % 2 == 0) && (i > 0), 1'b0, 8'(i % 2)};
            checks++;
            if ({busy, tick, done, count} !== exp) begin
                $display("FAIL restart[%0d]: got %h expected %h", i, {busy, tick, done, count}, exp);
                errors++;
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_hold();
        test_stop();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
